// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, issues one outstanding imem read, and registers the word with its PC for decode.
// Latency: accept in cycle N, response in cycle M>N, instr_valid in cycle M+1; at least 3 cycles per instruction.
// Backpressure: the request holds with a stable address until it is accepted; the word stays in HOLD until instr_ready.
module instr_fetch #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_pc,
    input  logic [XLEN-1:0] branch_offset,
    output logic            fetch_misalign
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            req_en;
    logic            instr_valid_nxt;
    logic            misalign_nxt;
    logic            load_instr;
    logic            req_fire;
    logic [XLEN-1:0] target;

    // req_en keeps the request low for the first cycle after reset release.
    assign imem_req_valid = (state == ST_REQ) && req_en;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign target         = branch_pc + branch_offset;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_valid_nxt = instr_valid;
        misalign_nxt    = fetch_misalign;
        load_instr      = 1'b0;

        case (state)
            ST_REQ: begin
                if (req_fire) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    load_instr      = 1'b1;
                    instr_valid_nxt = 1'b1;
                    state_nxt       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_nxt          = pc + XLEN'(4);
                    instr_valid_nxt = 1'b0;
                    state_nxt       = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_REQ;
        endcase

        // A redirect wins over everything; a read still in flight must be drained first.
        if (branch_taken) begin
            pc_nxt          = {target[XLEN-1:2], 2'b00};
            instr_valid_nxt = 1'b0;
            load_instr      = 1'b0;
            misalign_nxt    = fetch_misalign | (target[1:0] != 2'b00);
            if (((state == ST_REQ) && req_fire) ||
                ((state == ST_WAIT) && !imem_rsp_valid) ||
                ((state == ST_DRAIN) && !imem_rsp_valid))
                state_nxt = ST_DRAIN;
            else
                state_nxt = ST_REQ;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_REQ;
            pc             <= RESET_PC;
            req_en         <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= '0;
            instr_pc       <= '0;
            fetch_misalign <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            req_en         <= 1'b1;
            instr_valid    <= instr_valid_nxt;
            fetch_misalign <= misalign_nxt;
            if (load_instr) begin
                instr    <= imem_rsp_data;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one task per scenario, inline checks sampled 1ns after the rising edge.
module tb_instr_fetch;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            branch_taken = 1'b0;
    logic [XLEN-1:0] branch_pc = '0;
    logic [XLEN-1:0] branch_offset = '0;
    logic            fetch_misalign;

    int n_cmp = 0;
    int n_bad = 0;
    bit auto_rsp = 1'b1;

    instr_fetch #(.XLEN(XLEN), .RESET_PC(64'h100)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .branch_taken   (branch_taken),
        .branch_pc      (branch_pc),
        .branch_offset  (branch_offset),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        return 32'hC0DE_0000 ^ a[31:0];
    endfunction

    // One clock: note any handshake before the edge, then drive the 1-cycle-later response.
    task automatic cyc();
        bit              hs;
        logic [XLEN-1:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_addr;
        @(posedge clk);
        #1;
        branch_taken   = 1'b0;
        imem_rsp_valid = 1'b0;
        if (hs && auto_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(a);
        end
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        imem_rsp_valid = 1'b0;
        branch_taken   = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_instr_pc", instr_pc, 64'd0);
        chk("rst_misalign", {63'd0, fetch_misalign}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_req_low_first_cycle", {63'd0, imem_req_valid}, 64'd0);
    endtask

    task automatic test_stream();
        logic [XLEN-1:0] a;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        auto_rsp       = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            a = 64'h100 + 64'(4 * k);
            chk("stream_req_valid", {63'd0, imem_req_valid}, 64'd1);
            chk("stream_addr", imem_addr, a);
            cyc();
            chk("stream_wait_no_req", {63'd0, imem_req_valid}, 64'd0);
            chk("stream_wait_no_instr", {63'd0, instr_valid}, 64'd0);
            cyc();
            chk("stream_instr_valid", {63'd0, instr_valid}, 64'd1);
            chk("stream_instr", {32'd0, instr}, {32'd0, mem_word(a)});
            chk("stream_instr_pc", instr_pc, a);
            cyc();
        end
        chk("stream_next_addr", imem_addr, 64'h10C);
    endtask

    task automatic test_req_stall();
        do_reset();
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("stall_req_held", {63'd0, imem_req_valid}, 64'd1);
            chk("stall_addr_stable", imem_addr, 64'h100);
            cyc();
        end
        imem_req_ready = 1'b1;
        chk("stall_accept_valid", {63'd0, imem_req_valid}, 64'd1);
        cyc();
        chk("stall_one_wait", {63'd0, instr_valid}, 64'd0);
        cyc();
        chk("stall_instr_valid", {63'd0, instr_valid}, 64'd1);
        chk("stall_instr_pc", instr_pc, 64'h100);
    endtask

    task automatic test_hold();
        for (int k = 0; k < 4; k++) begin
            chk("hold_valid", {63'd0, instr_valid}, 64'd1);
            chk("hold_instr", {32'd0, instr}, {32'd0, mem_word(64'h100)});
            chk("hold_pc", instr_pc, 64'h100);
            chk("hold_no_req", {63'd0, imem_req_valid}, 64'd0);
            cyc();
        end
        instr_ready = 1'b1;
        cyc();
        chk("hold_release_valid", {63'd0, instr_valid}, 64'd0);
        chk("hold_next_req", {63'd0, imem_req_valid}, 64'd1);
        chk("hold_next_addr", imem_addr, 64'h104);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        auto_rsp       = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        cyc();
        cyc();
        branch_taken  = 1'b1;
        branch_pc     = 64'h200;
        branch_offset = 64'hFFFF_FFFF_FFFF_FFF0;
        cyc();
        chk("rdw_drain_no_req", {63'd0, imem_req_valid}, 64'd0);
        cyc();
        chk("rdw_drain_hold", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        cyc();
        chk("rdw_squash_no_valid", {63'd0, instr_valid}, 64'd0);
        chk("rdw_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("rdw_target", imem_addr, 64'h1F0);
        auto_rsp = 1'b1;
        cyc();
        cyc();
        chk("rdw_new_instr", {32'd0, instr}, {32'd0, mem_word(64'h1F0)});
        chk("rdw_new_pc", instr_pc, 64'h1F0);
    endtask

    task automatic test_redirect_accept();
        do_reset();
        auto_rsp       = 1'b1;
        imem_req_ready = 1'b1;
        cyc();
        branch_taken  = 1'b1;
        branch_pc     = 64'h300;
        branch_offset = 64'h40;
        cyc();
        chk("rda_drain_no_req", {63'd0, imem_req_valid}, 64'd0);
        cyc();
        chk("rda_no_valid", {63'd0, instr_valid}, 64'd0);
        chk("rda_addr", imem_addr, 64'h340);
        chk("rda_req", {63'd0, imem_req_valid}, 64'd1);
    endtask

    task automatic test_misalign();
        do_reset();
        imem_req_ready = 1'b0;
        cyc();
        branch_taken  = 1'b1;
        branch_pc     = 64'h200;
        branch_offset = 64'h6;
        cyc();
        chk("mis_flag", {63'd0, fetch_misalign}, 64'd1);
        chk("mis_addr", imem_addr, 64'h204);
        imem_req_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("mis_fetch_pc", instr_pc, 64'h204);
        chk("mis_sticky", {63'd0, fetch_misalign}, 64'd1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_req_ready = 1'b1;
        auto_rsp       = 1'b1;
        cyc();
        cyc();
        auto_rsp = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("rmid_wait_state", {63'd0, imem_req_valid}, 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rmid_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rmid_instr", {32'd0, instr}, 64'd0);
        chk("rmid_instr_pc", instr_pc, 64'd0);
        @(posedge clk);
        #1;
        rstn           = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        cyc();
        chk("rmid_late_ignored", {63'd0, instr_valid}, 64'd0);
        chk("rmid_restart_req", {63'd0, imem_req_valid}, 64'd1);
        chk("rmid_restart_addr", imem_addr, 64'h100);
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_req_stall();
        test_hold();
        test_redirect_wait();
        test_redirect_accept();
        test_misalign();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
